// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit arbiter.
// Holds the arbiter state encoding and the busy-rise timeout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WAIT_HI,
        WAIT_LO
    } arb_state_t;

    // Cycles to wait for tx_busy to rise before assuming a zero-latency uart.
    localparam int WAIT_TIMEOUT = 15;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between packet sources, the arbiter and the uart transmitter.
// master: arbiter side (drives ready/grant/tx), slave: sources + uart.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic [GW-1:0]                grant_id;
    logic                         busy;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_send;
    logic                         tx_busy;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant_id, busy, tx_data, tx_send
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant_id, busy, tx_data, tx_send
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr.
// Ports: req (request vector), ptr (start index), idx (winner), found.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    always_comb begin
        // Rotate so that bit 0 is the highest-priority requester.
        rot   = N'({req, req} >> ptr);
        off   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = W'(k);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NUM_REQ packet sources, round-robin
// per packet, optional source header. Ports: clock, rst, bus (master).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int                   NUM_REQ   = 4,
    parameter int                   DATA_BITS = 8,
    parameter int                   HDR_EN    = 1,
    parameter logic [DATA_BITS-1:0] HDR_BASE  = 8'hA0
) (
    input  logic              clock,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);

    arb_state_t           state_q;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        ptr_q;
    logic [GW-1:0]        ptr_inc;
    logic [GW-1:0]        pick_idx;
    logic                 pick_found;
    logic                 busy_q;
    logic                 send_q;
    logic                 last_q;
    logic [DATA_BITS-1:0] data_q;
    logic [3:0]           tmo_q;
    logic [NUM_REQ-1:0]   ready;
    logic [DATA_BITS-1:0] src_data [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src_data[g] = bus.req_data[g*DATA_BITS +: DATA_BITS];
    end

    rr_picker #(
        .N (NUM_REQ),
        .W (GW)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign ptr_inc = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

    always_comb begin
        ready = '0;
        if (state_q == DATA && !bus.tx_busy) ready[grant_q] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
        end else begin
            send_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!bus.tx_busy && pick_found) begin
                        grant_q <= pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= (HDR_EN != 0) ? HDR : DATA;
                    end
                end
                HDR: begin
                    data_q  <= HDR_BASE + DATA_BITS'(grant_q);
                    send_q  <= 1'b1;
                    last_q  <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= WAIT_HI;
                end
                DATA: begin
                    if (bus.req_valid[grant_q] && !bus.tx_busy) begin
                        data_q  <= src_data[grant_q];
                        send_q  <= 1'b1;
                        last_q  <= bus.req_last[grant_q];
                        tmo_q   <= '0;
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // A uart that never raises busy is released by timeout.
                    if (bus.tx_busy || tmo_q == 4'(WAIT_TIMEOUT - 1)) begin
                        state_q <= WAIT_LO;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            ptr_q   <= ptr_inc;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_send   = send_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: header/data ordering, round-robin,
// stall, mid-packet reset and the zero-latency uart timeout path.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int FRAME = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus0 ();
    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus1 ();

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .HDR_EN(1), .HDR_BASE(8'hA0)
    ) dut0 (
        .clock (clk),
        .rst   (rst),
        .bus   (bus0)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .HDR_EN(0), .HDR_BASE(8'hA0)
    ) dut1 (
        .clock (clk),
        .rst   (rst),
        .bus   (bus1)
    );

    // uart model: busy for FRAME cycles after each accepted send.
    logic ubusy = 1'b0;
    int   bcnt  = 0;
    assign bus0.tx_busy = ubusy;
    assign bus1.tx_busy = 1'b0;

    always @(posedge clk) begin
        if (bus0.tx_send && !ubusy) begin
            ubusy <= 1'b1;
            bcnt  <= FRAME;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            bcnt  <= 0;
            ubusy <= 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;

    logic [8:0] mem [4][16];
    int         head [4];
    int         tail [4];
    logic [3:0] stall;
    logic [3:0] hs;
    logic [7:0] sent [64];
    int         sent_n;
    logic [1:0] gl [16];
    int         gl_n;
    logic       prev_busy;
    logic       rdy0_seen;
    logic [7:0] ex [16];
    logic [1:0] gx [8];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        stall = '0;
        hs    = '0;
    endtask

    task automatic clear_logs();
        sent_n    = 0;
        gl_n      = 0;
        rdy0_seen = 1'b0;
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        mem[s][tail[s] & 15] = {l, d};
        tail[s]++;
    endtask

    // One cycle: retire handshakes, monitor outputs, drive sources.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) if (hs[i]) head[i]++;
        if (bus0.tx_send === 1'b1) begin
            check("send_while_busy", 32'(bus0.tx_busy), 32'h0);
            if (sent_n < 64) sent[sent_n] = bus0.tx_data;
            sent_n++;
        end
        if (bus0.req_ready !== 4'b0000) begin
            check("ready_onehot", 32'($onehot(bus0.req_ready)), 32'h1);
            if (bus0.req_ready[0]) rdy0_seen = 1'b1;
        end
        if (bus0.busy === 1'b1 && prev_busy !== 1'b1) begin
            if (gl_n < 16) gl[gl_n] = bus0.grant_id;
            gl_n++;
        end
        prev_busy = bus0.busy;
        for (int i = 0; i < 4; i++) begin
            bus0.req_valid[i] = (head[i] < tail[i]) && !stall[i];
            bus0.req_data[i*8 +: 8] = mem[i][head[i] & 15][7:0];
            bus0.req_last[i] = mem[i][head[i] & 15][8];
        end
        hs = bus0.req_valid & bus0.req_ready;
    endtask

    task automatic run_until(input int nbytes, input int limit);
        int c;
        c = 0;
        while (c < limit && !(sent_n >= nbytes && bus0.busy === 1'b0)) begin
            step();
            c++;
        end
        check("done_timeout", 32'(c < limit), 32'h1);
    endtask

    task automatic cmp_log(input string tag, input int n, input int ng);
        check({tag, "_count"}, 32'(sent_n), 32'(n));
        for (int i = 0; i < n && i < 16; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(sent[i]), 32'(ex[i]));
        end
        check({tag, "_grants"}, 32'(gl_n), 32'(ng));
        for (int i = 0; i < ng && i < 8; i++) begin
            check($sformatf("%s_grant%0d", tag, i), 32'(gl[i]), 32'(gx[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_srcs();
        step();
        step();
        clear_logs();
    endtask

    initial begin
        int         c;
        int         k1;
        int         n1;
        int         t1 [8];
        logic [7:0] d1 [8];
        logic [7:0] b1 [3];
        logic       h1;
        int         ix;

        bus0.req_valid = '0;
        bus0.req_data  = '0;
        bus0.req_last  = '0;
        bus1.req_valid = '0;
        bus1.req_data  = '0;
        bus1.req_last  = '0;
        prev_busy      = 1'b0;
        clear_srcs();
        clear_logs();

        // Reset values.
        repeat (3) step();
        check("rst_ready", 32'(bus0.req_ready), 32'h0);
        check("rst_send", 32'(bus0.tx_send), 32'h0);
        check("rst_data", 32'(bus0.tx_data), 32'h0);
        check("rst_busy", 32'(bus0.busy), 32'h0);
        check("rst_grant", 32'(bus0.grant_id), 32'h0);
        check("rst_ptr", 32'(dut0.ptr_q), 32'h0);

        // Source 1, three bytes.
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        rst = 1'b0;
        run_until(4, 300);
        ex[0] = 8'hA1; ex[1] = 8'h11; ex[2] = 8'h22; ex[3] = 8'h33;
        gx[0] = 2'd1;
        cmp_log("t2", 4, 1);
        check("t2_txbusy_low", 32'(bus0.tx_busy), 32'h0);
        check("t2_ptr", 32'(dut0.ptr_q), 32'h2);

        // Sources 0 and 2 valid at reset release, single-byte packets.
        do_reset();
        push(0, 8'h10, 1'b1);
        push(2, 8'h20, 1'b1);
        step();
        rst = 1'b0;
        step();
        check("t3_lat1_send", 32'(bus0.tx_send), 32'h0);
        step();
        check("t3_lat2_send", 32'(bus0.tx_send), 32'h1);
        check("t3_lat2_data", 32'(bus0.tx_data), 32'hA0);
        run_until(4, 300);
        ex[0] = 8'hA0; ex[1] = 8'h10; ex[2] = 8'hA2; ex[3] = 8'h20;
        gx[0] = 2'd0; gx[1] = 2'd2;
        cmp_log("t3", 4, 2);

        // All four sources, two-byte packets; source 0 has two packets.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            push(s, 8'(s * 16), 1'b0);
            push(s, 8'(s * 16 + 1), 1'b1);
        end
        push(0, 8'h02, 1'b0);
        push(0, 8'h03, 1'b1);
        rst = 1'b0;
        run_until(15, 800);
        ix = 0;
        for (int g = 0; g < 5; g++) begin
            int s;
            int p;
            s = g % 4;
            p = g / 4;
            gx[g] = 2'(s);
            ex[ix] = 8'hA0 + 8'(s);
            ex[ix + 1] = 8'(s * 16 + p * 2);
            ex[ix + 2] = 8'(s * 16 + p * 2 + 1);
            ix = ix + 3;
        end
        cmp_log("t4", 15, 5);

        // Source 3 stalls mid-packet while source 0 waits.
        do_reset();
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b1);
        rst = 1'b0;
        c = 0;
        while (sent_n < 2 && c < 100) begin
            step();
            c++;
        end
        check("t5_first_timeout", 32'(c < 100), 32'h1);
        stall[3] = 1'b1;
        push(0, 8'h01, 1'b1);
        repeat (50) step();
        check("t5_hold_grant", 32'(bus0.grant_id), 32'h3);
        check("t5_hold_busy", 32'(bus0.busy), 32'h1);
        check("t5_hold_sent", 32'(sent_n), 32'h2);
        check("t5_src0_ready", 32'(rdy0_seen), 32'h0);
        stall[3] = 1'b0;
        run_until(5, 300);
        ex[0] = 8'hA3; ex[1] = 8'h31; ex[2] = 8'h32;
        ex[3] = 8'hA0; ex[4] = 8'h01;
        gx[0] = 2'd3; gx[1] = 2'd0;
        cmp_log("t5", 5, 2);

        // Reset during WAIT_LO of byte 2 of a 4-byte packet.
        do_reset();
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b0);
        push(1, 8'h44, 1'b1);
        rst = 1'b0;
        c = 0;
        while (!(sent_n == 3 && dut0.state_q == WAIT_LO) && c < 200) begin
            step();
            c++;
        end
        check("t6_reach_timeout", 32'(c < 200), 32'h1);
        rst = 1'b1;
        step();
        check("t6_ready", 32'(bus0.req_ready), 32'h0);
        check("t6_send", 32'(bus0.tx_send), 32'h0);
        check("t6_data", 32'(bus0.tx_data), 32'h0);
        check("t6_busy", 32'(bus0.busy), 32'h0);
        check("t6_grant", 32'(bus0.grant_id), 32'h0);
        check("t6_ptr", 32'(dut0.ptr_q), 32'h0);
        clear_srcs();
        clear_logs();
        push(1, 8'h55, 1'b1);
        push(3, 8'h77, 1'b1);
        rst = 1'b0;
        run_until(4, 300);
        ex[0] = 8'hA1; ex[1] = 8'h55; ex[2] = 8'hA3; ex[3] = 8'h77;
        gx[0] = 2'd1; gx[1] = 2'd3;
        cmp_log("t6", 4, 2);

        // No header, uart never raises busy: timeout path per byte.
        b1 = '{8'h55, 8'h66, 8'h77};
        k1 = 0;
        n1 = 0;
        h1 = 1'b0;
        for (int cy = 0; cy < 120; cy++) begin
            @(negedge clk);
            if (h1) k1++;
            if (bus1.tx_send === 1'b1) begin
                if (n1 < 8) begin
                    t1[n1] = cy;
                    d1[n1] = bus1.tx_data;
                end
                n1++;
            end
            bus1.req_valid = (k1 < 3) ? 4'b0001 : 4'b0000;
            bus1.req_data  = {24'h0, b1[k1 % 3]};
            bus1.req_last  = {3'b000, k1 == 2};
            h1 = bus1.req_valid[0] & bus1.req_ready[0];
        end
        check("t7_count", 32'(n1), 32'h3);
        check("t7_byte0", 32'(d1[0]), 32'h55);
        check("t7_byte1", 32'(d1[1]), 32'h66);
        check("t7_byte2", 32'(d1[2]), 32'h77);
        check("t7_gap1", 32'((t1[1] - t1[0]) >= 16), 32'h1);
        check("t7_gap2", 32'((t1[2] - t1[1]) >= 16), 32'h1);
        check("t7_busy", 32'(bus1.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
